dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_dwell_cnt.sv | 52 +++++
 rtl/dds_sweep_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sweep controller:
//   - default phase-increment width (M) and dwell-counter width (D)
//   - sweep FSM state encoding
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_M_DEFAULT = 27;
    localparam int DDS_D_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

endpackage : dds_pkg

// File: rtl/dds_dwell_cnt.sv
// ---------------------------------------------------------------------------
// dds_dwell_cnt
// Down-counter that measures how many RUN cycles the current tuning word has
// been held.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset (counter -> 0)
//   load   in   reload with max(dwell,1)-1 (start of a new word)
//   tick   in   count down one cycle (ignored while load is high)
//   dwell  in   D  dwell length in cycles, 0 is treated as 1
//   last   out  current cycle is the final cycle of this word
// ---------------------------------------------------------------------------
module dds_dwell_cnt
    import dds_pkg::*;
#(
    parameter int D = DDS_D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         tick,
    input  logic [D-1:0] dwell,
    output logic         last
);

    logic [D-1:0] cnt_q;
    logic [D-1:0] cnt_d;

    // The counter holds "cycles remaining after this one", so a dwell of 0
    // and a dwell of 1 both load 0 and give a single-cycle word.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (dwell == '0) ? '0 : dwell - D'(1);
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - D'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule : dds_dwell_cnt

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep controller driving a DDS tuning word. On start it latches
// the sweep configuration, clears the DDS phase accumulator for one cycle,
// then steps the tuning word from P_start by P_step every max(dwell,1)
// cycles while the word stays <= P_end. At the end it either restarts from
// P_start (loop) or pulses done and returns to idle. All outputs are flops.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, highest priority
//   start    in   one-cycle start request, accepted only in IDLE
//   abort    in   stop sweep and return to IDLE (wins over start)
//   loop     in   sampled at start: 1 = repeat sweep, 0 = single sweep
//   P_start  in   M  first tuning word
//   P_step   in   M  unsigned increment per dwell
//   P_end    in   M  last permitted tuning word
//   dwell    in   D  cycles per tuning word (0 treated as 1)
//   P        out  M  tuning word to DDS
//   val_in   out  DDS input valid
//   rst_ac   out  DDS phase-accumulator clear
//   ena_ac   out  DDS accumulator enable
//   busy     out  high in CLEAR and RUN
//   done     out  one-cycle pulse at natural end of a single sweep
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int M = DDS_M_DEFAULT,
    parameter int D = DDS_D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         loop,
    input  logic [M-1:0] P_start,
    input  logic [M-1:0] P_step,
    input  logic [M-1:0] P_end,
    input  logic [D-1:0] dwell,
    output logic [M-1:0] P,
    output logic         val_in,
    output logic         rst_ac,
    output logic         ena_ac,
    output logic         busy,
    output logic         done
);

    sweep_state_e state_q, state_d;

    // Configuration captured at the accepted start.
    logic [M-1:0] p_start_q, p_start_d;
    logic [M-1:0] p_step_q,  p_step_d;
    logic [M-1:0] p_end_q,   p_end_d;
    logic [D-1:0] dwell_q,   dwell_d;
    logic         loop_q,    loop_d;

    // Registered outputs.
    logic [M-1:0] p_q, p_d;
    logic         val_in_q, val_in_d;
    logic         rst_ac_q, rst_ac_d;
    logic         ena_ac_q, ena_ac_d;
    logic         busy_q,   busy_d;
    logic         done_q,   done_d;

    logic         cnt_load;
    logic         cnt_tick;
    logic         cnt_last;

    // One extra bit so a step past the top of the M-bit range compares as
    // larger than P_end instead of wrapping to a small word.
    logic [M:0]   p_next;

    dds_dwell_cnt #(.D(D)) u_dwell_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .tick  (cnt_tick),
        .dwell (dwell_q),
        .last  (cnt_last)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        p_start_d = p_start_q;
        p_step_d  = p_step_q;
        p_end_d   = p_end_q;
        dwell_d   = dwell_q;
        loop_d    = loop_q;
        p_d       = '0;
        val_in_d  = 1'b0;
        rst_ac_d  = 1'b0;
        ena_ac_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_tick  = 1'b0;
        p_next    = {1'b0, p_q} + {1'b0, p_step_q};

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    p_start_d = P_start;
                    p_step_d  = P_step;
                    p_end_d   = P_end;
                    dwell_d   = dwell;
                    loop_d    = loop;
                    state_d   = ST_CLEAR;
                    rst_ac_d  = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            ST_CLEAR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_RUN;
                    p_d      = p_start_q;
                    val_in_d = 1'b1;
                    ena_ac_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!cnt_last) begin
                    p_d      = p_q;
                    val_in_d = 1'b1;
                    ena_ac_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_tick = 1'b1;
                end else if (p_next <= {1'b0, p_end_q} || loop_q) begin
                    // Next word (or wrap back to the start) with no gap cycle.
                    p_d      = (p_next <= {1'b0, p_end_q}) ? p_next[M-1:0] : p_start_q;
                    val_in_d = 1'b1;
                    ena_ac_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the configuration registers are plain control flops, not a
    // memory, so they are reset along with everything else and the
    // controller comes out of reset in a fully known state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            p_start_q <= '0;
            p_step_q  <= '0;
            p_end_q   <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            p_q       <= '0;
            val_in_q  <= 1'b0;
            rst_ac_q  <= 1'b0;
            ena_ac_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_start_q <= p_start_d;
            p_step_q  <= p_step_d;
            p_end_q   <= p_end_d;
            dwell_q   <= dwell_d;
            loop_q    <= loop_d;
            p_q       <= p_d;
            val_in_q  <= val_in_d;
            rst_ac_q  <= rst_ac_d;
            ena_ac_q  <= ena_ac_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign P      = p_q;
    assign val_in = val_in_q;
    assign rst_ac = rst_ac_q;
    assign ena_ac = ena_ac_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : dds_sweep_ctrl
